nand_tester: RTL and testbench
==============================

NAND_TESTER -- requirements
Module: nand_tester

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of cycles each input vector is held before sampling; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to run one full test sweep.
REQ-005 The block SHALL have port dut_y, input, 1 bit: output of the 2-input NAND gate under test.
REQ-006 The block SHALL have port dut_a, output, 1 bit: first input driven to the gate under test.
REQ-007 The block SHALL have port dut_b, output, 1 bit: second input driven to the gate under test.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: high once a sweep completes, held until the next accepted start or reset.
REQ-010 The block SHALL have port pass, output, 1 bit: high with done when no vector failed.
REQ-011 The block SHALL have port err_count, output, 3 bits: number of failing vectors, 0..4.
REQ-012 The block SHALL have port fail_vec, output, 4 bits: bit v set when vector v = {dut_a,dut_b} failed.

Function
REQ-013 The block SHALL implement four states: IDLE, DRIVE, SAMPLE and DONE, with all outputs registered.
REQ-014 In IDLE and DONE, the block SHALL drive dut_a=0 and dut_b=0.
REQ-015 When start=1 in IDLE or DONE, the block SHALL take these actions on that edge: clear err_count, fail_vec, done and pass; set vector index v=0; set busy=1; go to DRIVE.
REQ-016 While busy=1, the block SHALL ignore start.
REQ-017 In DRIVE, the block SHALL drive {dut_a,dut_b}=v[1:0] and hold it for exactly SETTLE cycles via a down-counter, then go to SAMPLE.
REQ-018 In SAMPLE, which lasts one cycle, the block SHALL keep {dut_a,dut_b}=v and compare dut_y against expected ~(dut_a & dut_b).
REQ-019 On a SAMPLE mismatch, the block SHALL increment err_count by 1 and set fail_vec[v]; on a match, both SHALL be unchanged.
REQ-020 From SAMPLE with v<3, the block SHALL increment v and go to DRIVE; with v=3, it SHALL go to DONE.
REQ-021 The applied vector order SHALL be 00, 01, 10, 11, each held SETTLE+1 cycles in total across DRIVE and SAMPLE.
REQ-022 On entry to DONE, the block SHALL set busy=0, done=1 and pass=(err_count==0 including the final sample).
REQ-023 Latency SHALL be as follows: with start sampled at edge 0, done SHALL be high after edge 4*(SETTLE+1)+1; this is 13 edges for SETTLE=2.
REQ-024 err_count SHALL saturate naturally at 4 with no wrap, because the maximum is reached exactly.
REQ-025 A start arriving in the same cycle as the final SAMPLE SHALL be ignored.
REQ-026 A start arriving in DONE SHALL restart the sweep per REQ-015.
REQ-027 The block SHALL contain no combinational path from dut_y to any output.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE and set dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, v=0 and the settle counter to 0.
REQ-029 Reset SHALL take priority over start in the same cycle.
REQ-030 Reset mid-sweep SHALL abort the sweep and discard partial results, with no done pulse.

Verification
REQ-031 The bench SHALL cover reset behaviour: hold rst 2 cycles -> all outputs 0 and state IDLE; start held 0 -> outputs remain 0.
REQ-032 The bench SHALL cover a golden gate: dut_y = ~(dut_a&dut_b), SETTLE=2, start pulse -> dut_a/dut_b sequence 00,01,10,11 each held 3 cycles; done=1 after 13 edges; pass=1, err_count=0, fail_vec=4'b0000.
REQ-033 The bench SHALL cover a stuck-at-1 output: dut_y=1 -> done, pass=0, err_count=1, fail_vec=4'b1000.
REQ-034 The bench SHALL cover an AND gate as DUT: dut_y = dut_a&dut_b -> err_count=4, fail_vec=4'b1111, pass=0.
REQ-035 The bench SHALL cover start handling: start pulsed at edge 5 during busy -> ignored and results as in REQ-032; start pulsed in DONE -> done=0, err_count=0 next cycle, and a new sweep completes 13 edges later.
REQ-036 The bench SHALL cover reset mid-run: rst asserted while v=2 in DRIVE -> next cycle IDLE, busy=0, done=0, fail_vec=0; a subsequent start produces a full clean sweep.

Source files
------------

// File: rtl/nand_tester.sv
// Production tester for a 2-input NAND gate. It applies the vectors 00, 01, 10, 11,
// holds each one for SETTLE cycles, samples one cycle later and records which vectors failed.
module nand_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_v,     w_v_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [1:0] r_ab,    w_ab_nxt;
  logic       r_busy,  w_busy_nxt;
  logic       r_done,  w_done_nxt;
  logic       r_pass,  w_pass_nxt;
  logic [2:0] r_err,   w_err_nxt;
  logic [3:0] r_fail,  w_fail_nxt;
  logic       w_mismatch;

  // The comparison sees the registered drive values, so dut_y only reaches state.
  assign w_mismatch = dut_y != ~(r_ab[1] & r_ab[0]);

  always_comb begin
    // NOTE: every next-value signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_cnt_nxt   = r_cnt;
    w_ab_nxt    = r_ab;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;

    unique case (r_state)
      IDLE, DONE: begin
        w_ab_nxt = 2'b00;
        if (start) begin
          w_state_nxt = DRIVE;
          w_v_nxt     = 2'd0;
          w_cnt_nxt   = SETTLE_CNT;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = 3'd0;
          w_fail_nxt  = 4'b0000;
        end
      end

      DRIVE: begin
        w_ab_nxt = r_v;
        if (r_cnt <= 8'd1) begin
          w_state_nxt = SAMPLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end

      SAMPLE: begin
        if (w_mismatch) begin
          w_err_nxt        = r_err + 3'd1;
          w_fail_nxt[r_v]  = 1'b1;
        end
        if (r_v == 2'd3) begin
          // Four vectors at most, so err_count tops out at 4 and never wraps.
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 3'd0);
          w_ab_nxt    = 2'b00;
        end else begin
          w_state_nxt = DRIVE;
          w_v_nxt     = r_v + 2'd1;
          w_cnt_nxt   = SETTLE_CNT;
          w_ab_nxt    = r_v + 2'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples the pre-edge values of the others.
    if (rst) begin
      r_state <= IDLE;
      r_v     <= 2'd0;
      r_cnt   <= 8'd0;
      r_ab    <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
      r_fail  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ab    <= w_ab_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign dut_a     = r_ab[1];
  assign dut_b     = r_ab[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_nand_tester.sv
// Self-checking bench for nand_tester. Gate models stand in for the device under test,
// and a per-vector fault mask gives the expected report.
module tb_nand_tester;

  localparam int SETTLE = 2;
  localparam int SWEEP  = 4 * (SETTLE + 1);

  typedef enum {G_NAND, G_ONE, G_AND, G_ZERO, G_OR, G_FLIP} gate_e;

  typedef struct {
    gate_e      gate;
    int         extra_start;  // edge at which a stray start is pulsed, 0 = none
    logic [2:0] err;
    logic [3:0] fail;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_y;
  logic       dut_a, dut_b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  gate_e      gate = G_NAND;
  logic [3:0] flip_mask = 4'b0000;
  logic [1:0] ab;

  int n_checks = 0;
  int n_fail   = 0;

  nand_tester #(.SETTLE(SETTLE)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_y     (dut_y),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  assign ab = {dut_a, dut_b};

  always_comb begin
    dut_y = 1'b0;
    case (gate)
      G_NAND:  dut_y = ~(dut_a & dut_b);
      G_ONE:   dut_y = 1'b1;
      G_AND:   dut_y = dut_a & dut_b;
      G_ZERO:  dut_y = 1'b0;
      G_OR:    dut_y = dut_a | dut_b;
      G_FLIP:  dut_y = ~(dut_a & dut_b) ^ flip_mask[ab];
      default: dut_y = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep starting at edge 0 and checks the vector sequence and the final report.
  // done must be high after 13 edges counting the start edge (edges 0..12).
  task automatic sweep(input string tag, input logic [2:0] e_err, input logic [3:0] e_fail,
                       input int extra);
    bit         seq_ok = 1'b1;
    logic [1:0] exp_ab;
    start = 1'b1;
    tick();
    check({tag, "_accept"}, {busy, done, pass, err_count, fail_vec}, {1'b1, 1'b0, 1'b0, 3'd0, 4'd0});
    for (int k = 0; k < SWEEP; k++) begin
      exp_ab = 2'(k / (SETTLE + 1));
      if (ab !== exp_ab || busy !== 1'b1 || done !== 1'b0) seq_ok = 1'b0;
      start = (extra > 0 && k == extra - 1);
      tick();
    end
    start = 1'b0;
    check({tag, "_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_done"}, {done, busy, ab}, {1'b1, 1'b0, 2'b00});
    check({tag, "_err"}, err_count, e_err);
    check({tag, "_fail"}, fail_vec, e_fail);
    check({tag, "_pass"}, pass, 32'(e_err == 3'd0));
    tick();
    check({tag, "_hold"}, {done, busy, err_count, fail_vec}, {1'b1, 1'b0, e_err, e_fail});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[6];
    logic [3:0] mask;
    bit         no_done;

    tbl[0] = '{G_NAND, 0,  3'd0, 4'b0000};
    tbl[1] = '{G_NAND, 5,  3'd0, 4'b0000};
    tbl[2] = '{G_ONE,  0,  3'd1, 4'b1000};
    tbl[3] = '{G_AND,  0,  3'd4, 4'b1111};
    tbl[4] = '{G_ZERO, 0,  3'd3, 4'b0111};
    tbl[5] = '{G_OR,   12, 3'd2, 4'b1001};

    // Reset held two cycles with start asserted: reset wins, everything stays cleared.
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    check("reset_outputs", {dut_a, dut_b, busy, done, pass, err_count, fail_vec}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (4) tick();
    check("idle_outputs", {dut_a, dut_b, busy, done, pass, err_count, fail_vec}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      gate = tbl[i].gate;
      sweep($sformatf("vec%0d", i), tbl[i].err, tbl[i].fail, tbl[i].extra_start);
    end

    // Random per-vector faults: vector v fails exactly when mask bit v is set.
    gate = G_FLIP;
    for (int i = 0; i < 16; i++) begin
      mask      = 4'($urandom);
      flip_mask = mask;
      sweep($sformatf("rnd%0d", i), 3'($countones(mask)), mask, 0);
    end

    // Reset while vector 2 is in DRIVE: partial results vanish and no done follows.
    gate  = G_AND;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("pre_reset_state", {ab, busy, fail_vec}, {2'd2, 1'b1, 4'b0011});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset", {dut_a, dut_b, busy, done, pass, err_count, fail_vec}, 32'd0);
    no_done = 1'b1;
    for (int k = 0; k < SWEEP + 4; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
    end
    check("no_done_after_abort", 32'(no_done), 32'd1);

    gate = G_NAND;
    sweep("post_reset", 3'd0, 4'b0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
